fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 13 +
 rtl/stream_buf2.sv | 53 +++++
 rtl/fifo_drain.sv | 98 +++++++++
 tb/tb_fifo_drain.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain block: default data width and the
// controller state encoding.
package fifo_pkg;

  localparam int DWIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } drain_state_t;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ring buffer that sits between the FIFO read port and the
// downstream valid/ready interface. The head word is presented combinationally
// from storage so it stays stable until it is popped.
module stream_buf2 import fifo_pkg::*; #(
  parameter int DWIDTH = DWIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DWIDTH-1:0] head_data
);

  logic [DWIDTH-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A push into a full buffer is only safe when the head leaves in the same
  // cycle; popping an empty buffer is ignored.
  assign do_push = push && ((occ != 2'd2) || pop);
  assign do_pop  = pop && (occ != 2'd0);

  // Storage, pointers and occupancy; simultaneous push and pop keep occ as is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_drain.sv
// Pulls words out of an upstream synchronous-read FIFO and re-presents them
// on a valid/ready stream, tagging the last word of every BURST_LEN burst and
// counting delivered words. Reads are only issued when the two-entry buffer
// is guaranteed to have room for the returning word.
module fifo_drain import fifo_pkg::*; #(
  parameter int DWIDTH    = DWIDTH_DEFAULT,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       word_count
);

  localparam int              CNT_W    = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  drain_state_t     state;
  drain_state_t     state_next;
  logic             inflight;
  logic             pop;
  logic [1:0]       occ;
  logic [2:0]       committed;
  logic [CNT_W-1:0] burst_cnt;

  // Words already owned by the buffer after this cycle: stored, returning
  // from the FIFO, minus the one leaving downstream.
  assign pop        = m_valid & m_ready;
  assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = (state == ST_RUN) && !fifo_empty && (committed < 3'd2);

  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && (burst_cnt == LAST_IDX);
  assign busy    = (state != ST_IDLE);

  stream_buf2 #(.DWIDTH(DWIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  // Next-state logic: DRAIN lingers until nothing is buffered or returning.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable) begin
          state_next = ST_RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus the one-cycle read-in-flight marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
    end
  end

  // Burst position and delivered-word total advance on every accepted word;
  // neither is touched by state changes, only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt  <= '0;
      word_count <= 16'd0;
    end else if (pop) begin
      burst_cnt  <= (burst_cnt == LAST_IDX) ? '0 : burst_cnt + CNT_W'(1);
      word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: an upstream FIFO model feeds the DUT,
// and a queue-based scoreboard predicts order, burst tags and word totals.
module tb_fifo_drain;
  import fifo_pkg::*;

  localparam int DW = DWIDTH_DEFAULT;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   word_count;

  fifo_drain #(.DWIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .word_count (word_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] expQ[$];
  int            popCount = 0;
  logic [15:0]   wcModel = 16'd0;
  int            readsTotal = 0;
  int            popsTotal = 0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData = '0;
  logic          prevLast = 1'b0;
  logic          obsValid;
  logic          obsRd;
  logic          obsBusy;

  // Compares one observed value with its expected value and counts it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Places a word into the upstream FIFO and the expected output order
  task automatic pushWord(input logic [DW-1:0] w);
    fifoQ.push_back(w);
    expQ.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic pushRandom(input int n);
    for (int i = 0; i < n; i++) pushWord(DW'($urandom));
  endtask

  // One clock: observe and score at the falling edge, then update the FIFO
  // model just after the rising edge
  task automatic runCycle();
    logic          rdNow;
    logic          popNow;
    logic [DW-1:0] want;
    @(negedge clk);
    rdNow    = fifo_rd_en;
    popNow   = m_valid & m_ready;
    obsValid = m_valid;
    obsRd    = fifo_rd_en;
    obsBusy  = busy;
    if (fifo_empty) checkOutput("rd_en_while_empty", fifo_rd_en, 0);
    if (prevStall) begin
      checkOutput("stall_valid", m_valid, 1);
      checkOutput("stall_data", m_data, prevData);
      checkOutput("stall_last", m_last, prevLast);
    end
    if (m_valid) checkOutput("m_last", m_last, ((popCount % BL) == BL - 1));
    else         checkOutput("m_last_idle", m_last, 0);
    if (popNow) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_pop", m_valid, 0);
      end else begin
        want = expQ.pop_front();
        checkOutput("m_data", m_data, want);
      end
      popCount++;
      wcModel++;
      popsTotal++;
    end
    prevStall = m_valid & ~m_ready;
    prevData  = m_data;
    prevLast  = m_last;
    if (rdNow) readsTotal++;
    checkOutput("buffer_bound", ((readsTotal - popsTotal) > 2), 0);
    @(posedge clk);
    #1;
    if (rdNow && (fifoQ.size() > 0)) fifo_data = fifoQ.pop_front();
    fifo_empty = (fifoQ.size() == 0);
    checkOutput("word_count", word_count, wcModel);
  endtask

  task automatic applyStimulus(input logic en, input logic rdy);
    enable  = en;
    m_ready = rdy;
    runCycle();
  endtask

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized soak
  initial begin
    int   startPops;
    logic seen;

    rst = 1'b0; enable = 1'b1; fifo_empty = 1'b0; fifo_data = '0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_rd_en", fifo_rd_en, 0);
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_m_data", m_data, 0);
      checkOutput("rst_m_last", m_last, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_word_count", word_count, 0);
    end
    @(posedge clk); #1;
    enable = 1'b0; fifo_empty = 1'b1; rst = 1'b1;
    applyStimulus(0, 1);

    $display("[TB] stream of 31..24");
    for (int v = 31; v >= 24; v--) pushWord(DW'(v));
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1);
      if (i <= 2)       checkOutput("first_valid_latency", obsValid, 0);
      else if (i <= 10) checkOutput("stream_valid", obsValid, 1);
    end
    checkOutput("stream_word_count", word_count, 16'd8);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);
    checkOutput("stream_idle", busy, 0);

    $display("[TB] backpressure");
    pushRandom(8);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0);
      checkOutput("bp_valid", obsValid, 1);
      if (i > 0) checkOutput("bp_rd_en", obsRd, 0);
    end
    for (int i = 0; (i < 20) && (expQ.size() > 0); i++) applyStimulus(1, 1);
    checkOutput("bp_delivered", expQ.size(), 0);

    $display("[TB] underflow");
    pushRandom(3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1);
      checkOutput("uf_busy", obsBusy, 1);
    end
    checkOutput("uf_delivered", expQ.size(), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1);
    checkOutput("uf_idle", busy, 0);

    $display("[TB] drain");
    pushRandom(6);
    seen = 1'b0;
    for (int i = 0; (i < 10) && !seen; i++) begin
      applyStimulus(1, 1);
      seen = obsRd;
    end
    checkOutput("drain_read_seen", seen, 1);
    obsBusy = 1'b1;
    for (int i = 0; (i < 20) && obsBusy; i++) applyStimulus(0, 1);
    checkOutput("drain_idle", busy, 0);
    checkOutput("drain_flushed", expQ.size(), fifoQ.size());

    $display("[TB] async reset mid-burst");
    pushRandom(4);
    startPops = popsTotal;
    for (int i = 0; (i < 12) && ((popsTotal - startPops) < 2); i++) applyStimulus(1, 1);
    checkOutput("ar_two_popped", popsTotal - startPops, 2);
    #2;
    rst = 1'b0; enable = 1'b0;
    #1;
    checkOutput("ar_rd_en", fifo_rd_en, 0);
    checkOutput("ar_m_valid", m_valid, 0);
    checkOutput("ar_m_data", m_data, 0);
    checkOutput("ar_m_last", m_last, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_word_count", word_count, 0);
    fifoQ.delete(); expQ.delete();
    popCount = 0; wcModel = 16'd0; readsTotal = 0; popsTotal = 0;
    prevStall = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1);
      checkOutput("ar_quiet_valid", obsValid, 0);
      checkOutput("ar_quiet_rd", obsRd, 0);
    end
    pushRandom(8);
    for (int i = 0; (i < 20) && (expQ.size() > 0); i++) applyStimulus(1, 1);
    checkOutput("ar_session_done", expQ.size(), 0);

    $display("[TB] random soak");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) pushRandom($urandom_range(1, 4));
      applyStimulus(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; (i < 2000) && (expQ.size() > 0); i++) applyStimulus(1, 1);
    checkOutput("final_delivered", expQ.size(), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1);
    checkOutput("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
